// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//  Bundles the request, response and ALU-side signals of alu_share_arbiter.
//  Modports:
//   slave  - the arbiter: takes requests and alu_out, drives ready/response/ALU operands/busy
//   master - the surroundings: requesters, response consumers and the ALU instance
//  Signals (N = 0,1):
//   reqN_valid/ready/op/a/b/tag  request channel
//   rspN_valid/ready/result/tag  response channel
//   alu_a/alu_b/alu_sel/alu_out  ALU connection
//   busy                         arbiter not idle
interface alu_share_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4,
   parameter int unsigned TAG_W  = 4
);
   logic              req0_valid;
   logic              req0_ready;
   logic [OP_W-1:0]   req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [TAG_W-1:0]  req0_tag;
   logic              req1_valid;
   logic              req1_ready;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [TAG_W-1:0]  req1_tag;
   logic              rsp0_valid;
   logic              rsp0_ready;
   logic [DATA_W-1:0] rsp0_result;
   logic [TAG_W-1:0]  rsp0_tag;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp1_result;
   logic [TAG_W-1:0]  rsp1_tag;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_sel;
   logic [DATA_W-1:0] alu_out;
   logic              busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
      input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
      output req0_ready, req1_ready,
      input  rsp0_ready, rsp1_ready,
      output rsp0_valid, rsp0_result, rsp0_tag,
      output rsp1_valid, rsp1_result, rsp1_tag,
      output alu_a, alu_b, alu_sel, busy,
      input  alu_out
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req0_tag,
      output req1_valid, req1_op, req1_a, req1_b, req1_tag,
      input  req0_ready, req1_ready,
      output rsp0_ready, rsp1_ready,
      input  rsp0_valid, rsp0_result, rsp0_tag,
      input  rsp1_valid, rsp1_result, rsp1_tag,
      input  alu_a, alu_b, alu_sel, busy,
      output alu_out
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//  Shares one combinational ALU between two requesters (0: integer issue, 1: branch unit).
//  One op in flight: IDLE accepts a request, EXEC lets the ALU settle on registered operands
//  and captures its output, RESP offers result and tag to the owning requester.
//  Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus_io - alu_share_arbiter_if.slave: request/response channels, ALU operands, busy
//  Configuration:
//   ALU_ARB_FIXED_PRI_EN - when defined, req0 wins every tie (req1 may starve);
//                          default is round-robin on ties.
module alu_share_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4,
   parameter int unsigned TAG_W  = 4
) (
   input logic                clk,
   input logic                rst_n,
   alu_share_arbiter_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e            state_q;
   logic              owner_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [OP_W-1:0]   sel_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] result_q;
   logic              rsp0_valid_q;
   logic              rsp1_valid_q;
   logic              busy_q;
`ifndef ALU_ARB_FIXED_PRI_EN
   logic              last_q;  // owner of the most recently completed op
`endif

   logic grant0;
   logic grant1;
   logic rsp_hs;

   // Grants are only meaningful in IDLE, so they double as the ready outputs.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == StIdle) begin
`ifdef ALU_ARB_FIXED_PRI_EN
         grant0 = bus_io.req0_valid;
         grant1 = bus_io.req1_valid & ~bus_io.req0_valid;
`else
         grant0 = bus_io.req0_valid & (~bus_io.req1_valid | last_q);
         grant1 = bus_io.req1_valid & (~bus_io.req0_valid | ~last_q);
`endif
      end
   end

   assign rsp_hs = (state_q == StResp) & (owner_q ? bus_io.rsp1_ready : bus_io.rsp0_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         sel_q        <= '0;
         tag_q        <= '0;
         result_q     <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
         last_q       <= 1'b1;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant0 | grant1) begin
                  sel_q   <= grant1 ? bus_io.req1_op  : bus_io.req0_op;
                  a_q     <= grant1 ? bus_io.req1_a   : bus_io.req0_a;
                  b_q     <= grant1 ? bus_io.req1_b   : bus_io.req0_b;
                  tag_q   <= grant1 ? bus_io.req1_tag : bus_io.req0_tag;
                  owner_q <= grant1;
                  busy_q  <= 1'b1;
                  state_q <= StExec;
               end
            end
            StExec: begin
               result_q     <= bus_io.alu_out;
               rsp0_valid_q <= ~owner_q;
               rsp1_valid_q <= owner_q;
               state_q      <= StResp;
            end
            StResp: begin
               if (rsp_hs) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
                  last_q       <= owner_q;
`endif
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.req0_ready  = grant0;
   assign bus_io.req1_ready  = grant1;
   assign bus_io.rsp0_valid  = rsp0_valid_q;
   assign bus_io.rsp1_valid  = rsp1_valid_q;
   assign bus_io.rsp0_result = result_q;
   assign bus_io.rsp1_result = result_q;
   assign bus_io.rsp0_tag    = tag_q;
   assign bus_io.rsp1_tag    = tag_q;
   assign bus_io.alu_a       = a_q;
   assign bus_io.alu_b       = b_q;
   assign bus_io.alu_sel     = sel_q;
   assign bus_io.busy        = busy_q;

endmodule
